debouncer: RTL and testbench
============================

Name: debouncer

Overview:
- Consumes the synchronized level from the synchronizer stage and removes contact bounce and glitches.
- Outputs a clean level plus one-cycle rising/falling event strobes.
- Optional long-press/auto-repeat strobe for push-buttons.
- Sits between the synchronizer and the user logic: keypad/button/encoder front-ends.

Parameters:
- STABLE_CYCLES, 16: consecutive cycles the input must differ from the current output before the output flips; must be >= 1.
- START_STATE, 0: output level after reset.
- LONG_CYCLES, 1024: cycles of debounced-high (after a debounced rising edge) before the first long_press strobe; must be >= 1. Used only with the optional feature.
- REPEAT_CYCLES, 256: period of repeat strobes after the first long_press; 0 = no repeat. Used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- in  input  1  level already synchronized to clk (synchronizer output).
- out  output  1  debounced level.
- rising_edge  output  1  one-cycle strobe; high in the first cycle out shows 1 after a 0.
- falling_edge  output  1  one-cycle strobe; high in the first cycle out shows 0 after a 1.
- long_press  output  1  one-cycle strobe for long-press/repeat; constant 0 when the feature is compiled out.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; all registers update on posedge clk only.
- Reset values:
  - out = START_STATE.
  - rising_edge = falling_edge = long_press = 0.
  - Settle counter = 0; hold counter = 0, disarmed.
- rst dominates everything in the same cycle. Reset mid-settle or mid-hold discards progress; no strobe is emitted on reset, even if out changes value.
- Settle counter width is max(1, clog2(STABLE_CYCLES)); it never wraps.
- FSM (encoded as out + settle counter != 0):
  - STABLE: in == out, counter 0.
  - SETTLING: in != out seen, counter counting.
- Per edge (not in reset):
  - in == out: counter <= 0; stay or return to STABLE. A bounce back aborts the settle with no output change.
  - in != out and counter == STABLE_CYCLES-1: out <= in; counter <= 0; the matching edge strobe <= 1.
  - in != out otherwise: counter <= counter+1.
- Latency: if in first differs from out at edge t and stays different, out flips at edge t+STABLE_CYCLES-1 and is visible in the following cycle. STABLE_CYCLES=1 gives a plain 1-cycle register of in.
- Strobes are registered and high exactly one cycle. rising_edge and falling_edge are never high together. Minimum spacing between strobes is STABLE_CYCLES cycles.
- Input toggling faster than STABLE_CYCLES: out never changes and no strobes are produced.

Optional Feature:
- Macro: DEBOUNCER_LONGPRESS_EN.
- Defined: a hold counter, wide enough for max(LONG_CYCLES, REPEAT_CYCLES), is implemented.
  - Armed and cleared to 0 on the cycle rising_edge is asserted.
  - While armed and out==1, it increments each cycle.
  - When it reaches LONG_CYCLES, long_press pulses 1 cycle.
  - Then, if REPEAT_CYCLES>0, long_press pulses every REPEAT_CYCLES cycles, the counter reloading for each period. If REPEAT_CYCLES==0, the counter saturates and disarms.
  - A falling_edge or rst disarms and clears it immediately; no strobe occurs in that cycle.
  - START_STATE=1 with in held high after reset produces no long_press, because there has been no rising_edge to arm it.
- Not defined: no hold counter logic; long_press tied to constant 0; parameters LONG_CYCLES and REPEAT_CYCLES ignored.

Test Plan (STABLE_CYCLES=4, START_STATE=0, LONG_CYCLES=20, REPEAT_CYCLES=8 unless noted):
- Reset then in=1 from edge 10 onward -> out=0 through edge 12; out=1 after edge 13; rising_edge high exactly that one cycle.
- Bounce: in pattern 1,1,1,0,1,1,1,0 repeating -> out stays 0, no strobes ever.
- Clean high then in=0 at edge 30 held -> out=0 after edge 33; falling_edge one cycle; rising_edge never concurrent.
- rst asserted for one cycle at the third consecutive differing sample -> counter cleared, out unchanged, no strobe; flip occurs 4 edges after rst deasserts if in still differs.
- STABLE_CYCLES=1 -> out equals in delayed by exactly 1 cycle; a strobe on every change.
- With DEBOUNCER_LONGPRESS_EN, in held high 60 cycles -> long_press at 20 cycles after rising_edge, then at +28, +36, +44, +52; releasing stops strobes. Same run without the macro -> long_press constant 0.

Source files
------------

// File: rtl/debouncer.sv
// Debouncer: a level must differ from the output for STABLE_CYCLES consecutive cycles before it is accepted.
// Define DEBOUNCER_LONGPRESS_EN to build the long-press / auto-repeat strobe; otherwise long_press is tied to 0.
module debouncer #(
    parameter int   STABLE_CYCLES = 16,
    parameter logic START_STATE   = 1'b0,
    parameter int   LONG_CYCLES   = 1024,
    parameter int   REPEAT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rising_edge,
    output logic falling_edge,
    output logic long_press
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= START_STATE;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // The settle counter tracks how long in has disagreed with out; any agreement aborts the settle.
    always_comb begin
        out_d  = out_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (in == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            out_d  = in;
            cnt_d  = '0;
            rise_d = in;
            fall_d = ~in;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign out          = out_q;
    assign rising_edge  = rise_q;
    assign falling_edge = fall_q;

`ifdef DEBOUNCER_LONGPRESS_EN
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] LONG_TGT = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] REP_TGT  = HOLD_W'(REPEAT_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_inc, hold_tgt;
    logic              armed_q, armed_d;
    logic              rep_q, rep_d;
    logic              long_q, long_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            armed_q <= 1'b0;
            rep_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            armed_q <= armed_d;
            rep_q   <= rep_d;
            long_q  <= long_d;
        end
    end

    // First period runs to LONG_CYCLES, later periods to REPEAT_CYCLES, each restarting from 0.
    always_comb begin
        hold_d   = hold_q;
        armed_d  = armed_q;
        rep_d    = rep_q;
        long_d   = 1'b0;
        hold_inc = hold_q + HOLD_W'(1);
        hold_tgt = rep_q ? REP_TGT : LONG_TGT;
        if (rise_d) begin
            hold_d  = '0;
            armed_d = 1'b1;
            rep_d   = 1'b0;
        end else if (fall_d) begin
            hold_d  = '0;
            armed_d = 1'b0;
            rep_d   = 1'b0;
        end else if (armed_q && out_q) begin
            if (hold_inc == hold_tgt) begin
                long_d = 1'b1;
                if (REPEAT_CYCLES > 0) begin
                    hold_d = '0;
                    rep_d  = 1'b1;
                end else begin
                    hold_d  = hold_inc;
                    armed_d = 1'b0;
                end
            end else begin
                hold_d = hold_inc;
            end
        end
    end

    assign long_press = long_q;
`else
    // Long-press parameters stay on the interface for drop-in compatibility but have no effect here.
    localparam logic LP_PARAMS_SANE = (LONG_CYCLES >= 1) && (REPEAT_CYCLES >= 0);
    assign long_press = 1'b0 & LP_PARAMS_SANE;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: two instances (STABLE_CYCLES=4 and =1) checked every cycle against a window-based model,
// plus directed literal expectations at the interesting cycles.
module tb_debouncer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, in4, out4, re4, fe4, lp4;
    logic rst1, in1, out1, re1, fe1, lp1;

    int total = 0;
    int bad   = 0;

`ifdef DEBOUNCER_LONGPRESS_EN
    localparam logic LP = 1'b1;
`else
    localparam logic LP = 1'b0;
`endif

    debouncer #(.STABLE_CYCLES(4), .START_STATE(1'b0), .LONG_CYCLES(20), .REPEAT_CYCLES(8)) dut4 (
        .clk(clk), .rst(rst4), .in(in4), .out(out4),
        .rising_edge(re4), .falling_edge(fe4), .long_press(lp4)
    );

    debouncer #(.STABLE_CYCLES(1), .START_STATE(1'b0), .LONG_CYCLES(20), .REPEAT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst1), .in(in1), .out(out1),
        .rising_edge(re1), .falling_edge(fe1), .long_press(lp1)
    );

    // Model parameters per instance (index 0 = dut4, 1 = dut1)
    int P_S[2]     = '{4, 1};
    int P_LONG[2]  = '{20, 20};
    int P_REP[2]   = '{8, 0};
    bit P_START[2] = '{1'b0, 1'b0};

    bit m_out[2], m_rise[2], m_fall[2], m_long[2], m_armed[2];
    int m_re[2];
    int nsince[2];
    bit hist[2][16];
    bit active[2];
    int ecount = 0;

    bit s_in[2], s_rst[2];
    bit bouncing = 1'b0;
    int bounce_strobes = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output flips when the last STABLE_CYCLES samples since reset all disagree with it.
    task automatic model_step(input int d, input bit sin, input bit srst);
        bit flip;
        int k;
        if (srst) begin
            m_out[d]   = P_START[d];
            m_rise[d]  = 1'b0;
            m_fall[d]  = 1'b0;
            m_long[d]  = 1'b0;
            m_armed[d] = 1'b0;
            nsince[d]  = 0;
            return;
        end
        for (int i = 15; i > 0; i--) hist[d][i] = hist[d][i-1];
        hist[d][0] = sin;
        nsince[d]++;
        flip = (nsince[d] >= P_S[d]);
        for (int i = 0; i < P_S[d]; i++)
            if (hist[d][i] == m_out[d]) flip = 1'b0;
        m_rise[d] = 1'b0;
        m_fall[d] = 1'b0;
        m_long[d] = 1'b0;
        if (flip) begin
            m_out[d]   = sin;
            m_rise[d]  = sin;
            m_fall[d]  = !sin;
            m_armed[d] = sin;
            m_re[d]    = ecount;
        end else if (LP && m_armed[d] && m_out[d]) begin
            k = ecount - m_re[d];
            if (k == P_LONG[d] ||
                (P_REP[d] > 0 && k > P_LONG[d] && ((k - P_LONG[d]) % P_REP[d]) == 0))
                m_long[d] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        s_in[0]  <= in4;
        s_rst[0] <= rst4;
        s_in[1]  <= in1;
        s_rst[1] <= rst1;
    end

    always @(negedge clk) begin
        ecount++;
        if (bouncing && (re4 || fe4)) bounce_strobes++;
        for (int d = 0; d < 2; d++) begin
            if (s_rst[d]) active[d] = 1'b1;
            if (active[d]) begin
                model_step(d, s_in[d], s_rst[d]);
                chk(d == 0 ? "m4_out"  : "m1_out",  d == 0 ? out4 : out1, m_out[d]);
                chk(d == 0 ? "m4_rise" : "m1_rise", d == 0 ? re4  : re1,  m_rise[d]);
                chk(d == 0 ? "m4_fall" : "m1_fall", d == 0 ? fe4  : fe1,  m_fall[d]);
                chk(d == 0 ? "m4_long" : "m1_long", d == 0 ? lp4  : lp1,  m_long[d]);
            end
        end
    end

    task automatic seq4();
        step(3);
        chk("d4_reset_out", out4, 1'b0);
        chk("d4_reset_rise", re4, 1'b0);
        chk("d4_reset_fall", fe4, 1'b0);
        chk("d4_reset_long", lp4, 1'b0);
        rst4 = 1'b0;
        step(6);
        // rising: flips on the 4th differing sample
        in4 = 1'b1;
        step(3);
        chk("d4_rise_pre_out", out4, 1'b0);
        chk("d4_rise_pre_strobe", re4, 1'b0);
        step(1);
        chk("d4_rise_out", out4, 1'b1);
        chk("d4_rise_strobe", re4, 1'b1);
        chk("d4_rise_nofall", fe4, 1'b0);
        step(1);
        chk("d4_rise_one_cycle", re4, 1'b0);
        // held high: long press at +20, repeats at +28 ...
        step(19);
        chk("d4_long_first", lp4, LP);
        step(1);
        chk("d4_long_first_end", lp4, 1'b0);
        step(7);
        chk("d4_long_repeat", lp4, LP);
        step(1);
        chk("d4_long_repeat_end", lp4, 1'b0);
        step(26);
        in4 = 1'b0;
        step(3);
        chk("d4_fall_pre_out", out4, 1'b1);
        step(1);
        chk("d4_fall_out", out4, 1'b0);
        chk("d4_fall_strobe", fe4, 1'b1);
        chk("d4_fall_norise", re4, 1'b0);
        chk("d4_fall_nolong", lp4, 1'b0);
        step(1);
        chk("d4_fall_one_cycle", fe4, 1'b0);
        step(10);
        // bounce 1,1,1,0 repeating never settles
        bouncing = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in4 = (i % 4 != 3);
            step(1);
        end
        in4 = 1'b0;
        step(4);
        bouncing = 1'b0;
        chk("d4_bounce_out", out4, 1'b0);
        chk("d4_bounce_strobes", (bounce_strobes != 0), 1'b0);
        // reset on the third differing sample restarts the settle
        in4 = 1'b1;
        step(2);
        rst4 = 1'b1;
        step(1);
        chk("d4_midrst_out", out4, 1'b0);
        chk("d4_midrst_rise", re4, 1'b0);
        rst4 = 1'b0;
        step(3);
        chk("d4_midrst_pre_out", out4, 1'b0);
        step(1);
        chk("d4_midrst_flip_out", out4, 1'b1);
        chk("d4_midrst_flip_rise", re4, 1'b1);
        // reset while high: out returns to START_STATE without a falling strobe
        step(3);
        rst4 = 1'b1;
        step(1);
        chk("d4_hirst_out", out4, 1'b0);
        chk("d4_hirst_nofall", fe4, 1'b0);
        rst4 = 1'b0;
        step(4);
        chk("d4_hirst_reflip_out", out4, 1'b1);
        chk("d4_hirst_reflip_rise", re4, 1'b1);
        in4 = 1'b0;
        step(8);
    endtask

    task automatic seq1();
        logic [15:0] vec;
        logic b, prev;
        step(3);
        chk("d1_reset_out", out1, 1'b0);
        rst1 = 1'b0;
        step(2);
        vec  = 16'b1011_0010_0111_0100;
        prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b   = vec[15-i];
            in1 = b;
            step(1);
            chk("d1_follow_out", out1, b);
            chk("d1_follow_rise", re1, b & ~prev);
            chk("d1_follow_fall", fe1, ~b & prev);
            prev = b;
        end
        in1 = 1'b1;
        step(1);
        chk("d1_hold_rise", re1, 1'b1);
        step(20);
        chk("d1_long_once", lp1, LP);
        step(1);
        chk("d1_long_once_end", lp1, 1'b0);
        step(15);
        chk("d1_no_repeat", lp1, 1'b0);
        in1 = 1'b0;
        step(3);
    endtask

    initial begin
        rst4 = 1'b1;
        in4  = 1'b0;
        rst1 = 1'b1;
        in1  = 1'b0;
        fork
            seq4();
            seq1();
        join
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
